button_event_decoder: RTL

- Consumes the clean, debounced button level from the debounce stage.
- Classifies the level into single-cycle event pulses: press, release, click, double-click, long-press and auto-repeat.
- Sits between the debounce stage and the user-logic or control FSMs.
- All timing is counted in clk cycles; there is no prescaler.

---
 rtl/button_event_decoder_if.sv | 26 ++
 rtl/button_event_decoder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/button_event_decoder_if.sv
// Button decoder signal bundle: debounced level and enable in, registered event pulses out.
// There is no valid/ready handshake; every pulse is a single-cycle strobe.
interface button_event_decoder_if;
  logic       btn_db;
  logic       en;
  logic       held;
  logic       press_pulse;
  logic       release_pulse;
  logic       click;
  logic       double_click;
  logic       long_press;
  logic       repeat_pulse;
  logic [2:0] dbg_state;

  modport master (
    output btn_db, en,
    input  held, press_pulse, release_pulse, click, double_click,
           long_press, repeat_pulse, dbg_state
  );

  modport slave (
    input  btn_db, en,
    output held, press_pulse, release_pulse, click, double_click,
           long_press, repeat_pulse, dbg_state
  );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/click/double-click/long-press/repeat pulses.
// One shared cycle counter times the hold, gap and repeat intervals; it clears on every state change.
module button_event_decoder #(
  parameter int LONG_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int DBL_CYC    = 12_500_000,
  parameter int CNT_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  button_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_q;
  logic             rise;
  logic             fall;

  assign rise          = bus.btn_db & ~btn_q;
  assign fall          = ~bus.btn_db & btn_q;
  assign bus.held      = btn_q;
  assign bus.dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q             <= 1'b0;
      state             <= IDLE;
      cnt               <= '0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click         <= 1'b0;
      bus.double_click  <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
    end else begin
      btn_q             <= bus.btn_db;
      bus.press_pulse   <= bus.en & rise;
      bus.release_pulse <= bus.en & fall;
      bus.click         <= 1'b0;
      bus.double_click  <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;

      if (!bus.en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) state <= PRESS1;
          end
          PRESS1: begin
            if (fall) begin
              state <= GAP;
              cnt   <= '0;
            end else if (cnt == LONG_LIM) begin
              state          <= LONG;
              cnt            <= '0;
              bus.long_press <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            // A rise on the expiry cycle still counts as the second press.
            if (rise) begin
              state <= PRESS2;
              cnt   <= '0;
            end else if (cnt == DBL_LIM) begin
              state     <= IDLE;
              cnt       <= '0;
              bus.click <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESS2: begin
            if (fall) begin
              state            <= IDLE;
              cnt              <= '0;
              bus.double_click <= 1'b1;
            end else if (cnt == LONG_LIM) begin
              // The earlier short press is reported as a click alongside the long press.
              state          <= LONG;
              cnt            <= '0;
              bus.click      <= 1'b1;
              bus.long_press <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LONG: begin
            if (fall) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == REP_LIM) begin
              cnt              <= '0;
              bus.repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
